// File: rtl/round_div_pkg.sv
// Shared types for the round_div_pipe divide-by-2^k rounding pipeline.
package round_div_pkg;

  localparam int P_IN_WIDTH  = 8;
  localparam int P_OUT_WIDTH = 4;
  localparam int P_SHIFT_W   = 3;
  localparam int MODE_W      = 2;

  typedef enum logic [MODE_W-1:0] {
    FLOOR     = 2'd0,
    CEIL      = 2'd1,
    HALF_UP   = 2'd2,
    HALF_EVEN = 2'd3
  } rnd_mode_e;

  // Stage-1 payload: truncated quotient plus the rounding increment.
  typedef struct packed {
    logic [P_IN_WIDTH-1:0] q;
    logic                  inc;
  } s1_payload_t;

endpackage

// File: rtl/round_div_pipe_if.sv
// Valid/ready request and result channels of round_div_pipe.
interface round_div_pipe_if
  import round_div_pkg::*;
#(
  parameter int IN_WIDTH  = P_IN_WIDTH,
  parameter int OUT_WIDTH = P_OUT_WIDTH,
  parameter int SHIFT_W   = P_SHIFT_W
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  din;
  logic [SHIFT_W-1:0]   shift;
  logic [MODE_W-1:0]    mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] dout;
  logic                 ovf;

  // Master is the producer/consumer side, slave is the divider.
  modport master (
    output in_valid, din, shift, mode, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din, shift, mode, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/round_div_incr.sv
// Combinational quotient and rounding-increment for din / 2^shift.
module round_div_incr
  import round_div_pkg::*;
#(
  parameter int IN_WIDTH = P_IN_WIDTH,
  parameter int SHIFT_W  = P_SHIFT_W
)
(
  input  logic [IN_WIDTH-1:0] i_din,
  input  logic [SHIFT_W-1:0]  i_shift,
  input  rnd_mode_e           i_mode,
  output logic [IN_WIDTH-1:0] o_q,
  output logic                o_inc
);
  localparam logic [IN_WIDTH-1:0] L_ONE  = IN_WIDTH'(1'b1);
  localparam logic [IN_WIDTH-1:0] L_ZERO = {IN_WIDTH{1'b0}};
  localparam logic [SHIFT_W-1:0]  L_K1   = SHIFT_W'(1'b1);

  logic [IN_WIDTH-1:0] w_mask;
  logic [IN_WIDTH-1:0] w_rem;
  logic [IN_WIDTH-1:0] w_half;

  assign o_q    = i_din >> i_shift;
  assign w_mask = (L_ONE << i_shift) - L_ONE;
  assign w_rem  = i_din & w_mask;
  // Only meaningful for shift > 0; the k=0 case never looks at it.
  assign w_half = L_ONE << (i_shift - L_K1);

  // Rounding decision from the discarded remainder.
  always_comb begin
    o_inc = 1'b0;
    if (i_shift == {SHIFT_W{1'b0}}) begin
      o_inc = 1'b0;
    end else begin
      case (i_mode)
        FLOOR:     o_inc = 1'b0;
        CEIL:      o_inc = (w_rem != L_ZERO);
        HALF_UP:   o_inc = (w_rem >= w_half);
        HALF_EVEN: o_inc = (w_rem > w_half) || ((w_rem == w_half) && o_q[0]);
        default:   o_inc = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/round_div_pipe.sv
// Two-stage valid/ready divide-by-2^k with rounding and overflow flag.
// Define ROUND_DIV_SAT_EN to saturate dout on overflow instead of wrapping.
module round_div_pipe
  import round_div_pkg::*;
#(
  parameter int IN_WIDTH  = P_IN_WIDTH,
  parameter int OUT_WIDTH = P_OUT_WIDTH,
  parameter int SHIFT_W   = P_SHIFT_W
)
(
  input  logic            clk,
  input  logic            reset,
  round_div_pipe_if.slave bus
);
  logic                 w_s2_load;
  logic                 w_in_ready;
  logic                 w_accept;
  logic [IN_WIDTH-1:0]  w_q;
  logic                 w_inc;
  logic [IN_WIDTH:0]    w_sum;
  logic                 w_ovf;
  logic [OUT_WIDTH-1:0] w_dout;

  logic                 r_s1_valid;
  s1_payload_t          r_s1;
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_dout;
  logic                 r_ovf;

  round_div_incr #(
    .IN_WIDTH (IN_WIDTH),
    .SHIFT_W  (SHIFT_W)
  ) u_incr (
    .i_din   (bus.din),
    .i_shift (bus.shift),
    .i_mode  (rnd_mode_e'(bus.mode)),
    .o_q     (w_q),
    .o_inc   (w_inc)
  );

  // Stage 2 frees whenever it is empty or its item leaves this cycle.
  assign w_s2_load  = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_sum = (IN_WIDTH+1)'(r_s1.q) + (IN_WIDTH+1)'(r_s1.inc);
  assign w_ovf = |w_sum[IN_WIDTH:OUT_WIDTH];

`ifdef ROUND_DIV_SAT_EN
  // Clamp to the largest representable value when the result overflows.
  always_comb begin
    w_dout = w_sum[OUT_WIDTH-1:0];
    if (w_ovf) begin
      w_dout = {OUT_WIDTH{1'b1}};
    end else begin
      w_dout = w_sum[OUT_WIDTH-1:0];
    end
  end
`else
  assign w_dout = w_sum[OUT_WIDTH-1:0];
`endif

  // Stage 1: capture quotient and rounding increment on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1       <= {$bits(s1_payload_t){1'b0}};
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (w_accept) begin
        r_s1.q   <= P_IN_WIDTH'(w_q);
        r_s1.inc <= w_inc;
      end
    end
  end

  // Stage 2: apply the increment and hold the result until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_dout      <= {OUT_WIDTH{1'b0}};
      r_ovf       <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout <= w_dout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign bus.ovf       = r_ovf;

endmodule
